// File: rtl/disp_vram_rdresp_pkg.sv
// disp_rdresp_pkg: response codes, FSM states and beat sizing shared by disp_vram_rdresp
// Contents: RESP_OKAY/RESP_SLVERR, state_t {S_IDLE, S_BURST, S_DRAIN}, BEAT_BYTES, beat_shift()
package disp_rdresp_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int DEF_DATA_W = 64;
    localparam int BEAT_BYTES = DEF_DATA_W / 8;
    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;
    function automatic int beat_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction
endpackage

// File: rtl/disp_vram_rdresp_if.sv
// disp_vram_rdresp_if: AR and R channel bundle between the display VRAM read master and its responder
// Signals: araddr/arlen/arvalid/arready (address), rdata/rresp/rlast/rvalid/rready (read data)
// Modports: master drives AR and rready; slave drives arready and the R payload
interface disp_vram_rdresp_if
    import disp_rdresp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    modport master (
        output araddr, arlen, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  araddr, arlen, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/disp_vram_rdresp_fifo2.sv
// disp_rdresp_fifo2: two-entry output buffer for read beats
// Ports: ACLK, ARST (sync, active-high); push/din write an entry; pop retires head;
//        head is the oldest entry, count is the occupancy (0..2)
module disp_rdresp_fifo2 #(
    parameter int W = 67
) (
    input  logic         ACLK,
    input  logic         ARST,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic wp, rp;
    assign head = mem[rp];
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            wp <= 1'b0;
            rp <= 1'b0;
            count <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/disp_vram_rdresp.sv
// disp_vram_rdresp: AXI3-style INCR read responder serving bursts from a synchronous-read BRAM port
// Ports: ACLK, ARST (sync, active-high); axi = AR/R channels (slave modport);
//        mem_addr/mem_en to the BRAM, mem_rdata valid one cycle after mem_en
// Build option: DISP_RDRESP_PATTERN_EN returns replicated word indices instead of BRAM data
//               and holds mem_en low; the default build reads the BRAM
module disp_vram_rdresp
    import disp_rdresp_pkg::*;
#(
    parameter int          DATA_W    = DEF_DATA_W,
    parameter int          MEM_AW    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic               ACLK,
    input  logic               ARST,
    disp_vram_rdresp_if.slave  axi,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic               mem_en,
    input  logic [DATA_W-1:0]  mem_rdata
);
    localparam int SHIFT = beat_shift(DATA_W);
    localparam int EW = DATA_W + 3;
    state_t st;
    logic arready_q, inf_v, inf_last, inf_err;
    logic pop, issue, in_range, fifo_push, fifo_pop;
    logic [31:0] idx;
    logic [7:0] beats_left;
    logic [1:0] cnt;
    logic [2:0] occ;
    logic [DATA_W-1:0] beat_data;
    logic [EW-1:0] inf_entry, fifo_head, head;
`ifdef DISP_RDRESP_PATTERN_EN
    logic [31:0] inf_idx;
    assign beat_data = {(DATA_W/32){inf_idx}};
    assign mem_en = 1'b0;
    always_ff @(posedge ACLK) inf_idx <= idx;
`else
    assign beat_data = mem_rdata;
    assign mem_en = issue & in_range;
`endif
    assign in_range = (idx >> MEM_AW) == 32'd0;
    assign mem_addr = idx[MEM_AW-1:0];
    assign inf_entry = {inf_err ? {DATA_W{1'b0}} : beat_data, inf_err ? RESP_SLVERR : RESP_OKAY, inf_last};
    // The in-flight beat is presented directly when the buffer is empty, so the
    // first beat is valid the cycle BRAM data arrives; it is buffered only if not taken.
    assign head = cnt != 2'd0 ? fifo_head : (inf_v ? inf_entry : '0);
    assign axi.rvalid = cnt != 2'd0 || inf_v;
    assign axi.rdata = head[EW-1:3];
    assign axi.rresp = head[2:1];
    assign axi.rlast = head[0];
    assign axi.arready = arready_q;
    assign pop = axi.rvalid & axi.rready;
    assign fifo_pop = pop && cnt != 2'd0;
    assign fifo_push = inf_v && !(pop && cnt == 2'd0);
    // Occupancy after this cycle's pop, counting the beat in flight; a new issue must keep it within 2.
    assign occ = 3'(cnt) + 3'(inf_v) - 3'(pop);
    assign issue = st == S_BURST && occ < 3'd2;
    disp_rdresp_fifo2 #(.W(EW)) u_fifo (
        .ACLK(ACLK), .ARST(ARST), .push(fifo_push), .pop(fifo_pop),
        .din(inf_entry), .head(fifo_head), .count(cnt)
    );
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            st <= S_IDLE;
            arready_q <= 1'b0;
            idx <= 32'd0;
            beats_left <= 8'd0;
            inf_v <= 1'b0;
            inf_last <= 1'b0;
            inf_err <= 1'b0;
        end else begin
            inf_v <= issue;
            inf_last <= issue && beats_left == 8'd0;
            inf_err <= issue && !in_range;
            case (st)
                S_IDLE:
                    if (axi.arvalid && arready_q) begin
                        idx <= (axi.araddr - BASE_ADDR) >> SHIFT;
                        beats_left <= axi.arlen;
                        arready_q <= 1'b0;
                        st <= S_BURST;
                    end else arready_q <= 1'b1;
                S_BURST:
                    if (issue) begin
                        idx <= idx + 32'd1;
                        beats_left <= beats_left - 8'd1;
                        if (beats_left == 8'd0) st <= S_DRAIN;
                    end
                S_DRAIN:
                    if (pop && axi.rlast) begin
                        st <= S_IDLE;
                        arready_q <= 1'b1;
                    end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_disp_vram_rdresp.sv
// tb_disp_vram_rdresp: directed bench comparing disp_vram_rdresp beats against a burst-level model
module tb_disp_vram_rdresp;
    localparam logic [31:0] BASE = 32'h2000_0000;
    typedef struct {
        logic [63:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;
    logic ACLK = 1'b0;
    logic ARST = 1'b1;
    logic [15:0] mem_addr;
    logic mem_en;
    logic [63:0] mem_rdata = '0;
    disp_vram_rdresp_if #(.DATA_W(64)) bus();
    disp_vram_rdresp #(.DATA_W(64), .MEM_AW(16), .BASE_ADDR(BASE)) dut (
        .ACLK(ACLK), .ARST(ARST), .axi(bus),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata)
    );
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) if (mem_en) mem_rdata <= 64'(mem_addr);

    int errs = 0, checks = 0, cyc = 0, ar_c = 0, en_cnt = 0;
    bit pend = 0, hold = 0, rmode = 0;
    logic [66:0] held;
    beat_t e;
    beat_t exq[$];
    logic [63:0] got_d[$];
    logic [1:0] got_r[$];
    logic got_l[$];
    int got_c[$], ar_cycs[$], last_cycs[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lit(input logic [31:0] k);
`ifdef DISP_RDRESP_PATTERN_EN
        return {k, k};
`else
        return 64'(k);
`endif
    endfunction

    function automatic beat_t mk(input logic [31:0] k, input bit last);
        beat_t b;
        b.l = last;
        b.r = k < 32'h0001_0000 ? 2'b00 : 2'b10;
        b.d = k < 32'h0001_0000 ? lit(k) : 64'd0;
        return b;
    endfunction

    always @(negedge ACLK) begin
        cyc++;
        if (ARST) begin
            exq.delete();
            pend = 0;
            hold = 0;
        end else begin
            if (mem_en) en_cnt++;
`ifdef DISP_RDRESP_PATTERN_EN
            chk("mem_en_held_low", mem_en, 0);
`endif
            if (bus.arvalid && bus.arready) begin
                chk("ar_only_when_idle", exq.size(), 0);
                ar_cycs.push_back(cyc);
                ar_c = cyc;
                pend = 1;
                for (int i = 0; i <= int'(bus.arlen); i++)
                    exq.push_back(mk((bus.araddr - BASE) / 8 + 32'(i), i == int'(bus.arlen)));
            end
            if (hold) chk("hold_stable", {bus.rvalid, bus.rdata, bus.rresp, bus.rlast}, {1'b1, held});
            if (bus.rvalid) begin
                if (pend) chk("first_beat_latency", cyc - ar_c, 2);
                pend = 0;
                if (exq.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL spurious_beat: got rvalid=1 expected rvalid=0");
                end else if (bus.rready) begin
                    e = exq.pop_front();
                    chk("rdata", bus.rdata, e.d);
                    chk("rresp", bus.rresp, e.r);
                    chk("rlast", bus.rlast, e.l);
                    got_d.push_back(bus.rdata);
                    got_r.push_back(bus.rresp);
                    got_l.push_back(bus.rlast);
                    got_c.push_back(cyc);
                    if (bus.rlast) last_cycs.push_back(cyc);
                end
            end
            hold = bus.rvalid && !bus.rready;
            held = {bus.rdata, bus.rresp, bus.rlast};
        end
    end

    initial forever begin
        @(posedge ACLK);
        #1;
        bus.rready = rmode ? !bus.rready : 1'b1;
    end

    task automatic clear();
        got_d.delete();
        got_r.delete();
        got_l.delete();
        got_c.delete();
        ar_cycs.delete();
        last_cycs.delete();
        en_cnt = 0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input bit keep);
        int n = 0;
        bus.araddr = a;
        bus.arlen = l;
        bus.arvalid = 1'b1;
        do begin
            @(negedge ACLK);
            n++;
        end while (!bus.arready && n < 200);
        if (!bus.arready) begin
            checks++;
            errs++;
            $display("FAIL ar_accept_timeout: got arready=0 expected arready=1 within 200 cycles");
        end
        @(posedge ACLK);
        #1;
        if (!keep) bus.arvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while ((exq.size() != 0 || !bus.arready) && n < 2000);
        if (exq.size() != 0 || !bus.arready) begin
            checks++;
            errs++;
            $display("FAIL burst_timeout: got %0d beats owed expected 0", exq.size());
        end
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        int n;
        bus.arvalid = 1'b0;
        bus.araddr = '0;
        bus.arlen = '0;
        bus.rready = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_arready", bus.arready, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_rresp", bus.rresp, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge ACLK);
        #1;
        ARST = 1'b0;
        @(negedge ACLK);
        chk("arready_low_after_release", bus.arready, 0);
        @(negedge ACLK);
        chk("arready_high_in_idle", bus.arready, 1);
        @(posedge ACLK);
        #1;

        clear();
        send_ar(BASE, 8'd15, 0);
        wait_done();
        chk("A_beats", got_d.size(), 16);
        chk("A_first_data", got_d[0], lit(0));
        chk("A_last_data", got_d[15], lit(15));
        chk("A_beat15_not_last", got_l[14], 0);
        chk("A_beat16_last", got_l[15], 1);
        chk("A_no_bubbles", got_c[15] - got_c[0], 15);

        rmode = 1;
        clear();
        send_ar(BASE, 8'd15, 0);
        wait_done();
        rmode = 0;
        chk("B_beats", got_d.size(), 16);
        chk("B_beat8_data", got_d[7], lit(7));
        chk("B_beat16_last", got_l[15], 1);

        clear();
        send_ar(BASE + 32'(65534 * 8), 8'd3, 0);
        wait_done();
        chk("C_beats", got_d.size(), 4);
        chk("C_b1_data", got_d[0], lit(65534));
        chk("C_b2_data", got_d[1], lit(65535));
        chk("C_b3_data", got_d[2], 0);
        chk("C_b4_data", got_d[3], 0);
        chk("C_b2_resp", got_r[1], 2'b00);
        chk("C_b3_resp", got_r[2], 2'b10);
        chk("C_b4_resp", got_r[3], 2'b10);
        chk("C_b4_last", got_l[3], 1);
`ifndef DISP_RDRESP_PATTERN_EN
        chk("C_mem_en_pulses", en_cnt, 2);
`endif

        clear();
        send_ar(BASE + 32'(100 * 8), 8'd3, 1);
        send_ar(BASE + 32'(200 * 8), 8'd0, 0);
        wait_done();
        chk("D_beats", got_d.size(), 5);
        chk("D_single_data", got_d[4], lit(200));
        chk("D_single_last", got_l[4], 1);
        chk("D_first_last", got_l[3], 1);
        chk("D_second_ar_after_rlast", ar_cycs[1] - last_cycs[0], 1);

        clear();
        send_ar(BASE, 8'd15, 0);
        n = 0;
        while (got_d.size() < 5 && n < 200) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        ARST = 1'b1;
        @(posedge ACLK);
        #1;
        chk("E_beats_before_reset", got_d.size(), 5);
        chk("E_rvalid_after_reset", bus.rvalid, 0);
        chk("E_arready_after_reset", bus.arready, 0);
        ARST = 1'b0;
        @(posedge ACLK);
        #1;
        chk("E_arready_next_cycle", bus.arready, 1);
        clear();
        send_ar(BASE + 32'(300 * 8), 8'd3, 0);
        wait_done();
        chk("E_beats_new", got_d.size(), 4);
        chk("E_first_new", got_d[0], lit(300));
        chk("E_last_new", got_d[3], lit(303));

`ifdef DISP_RDRESP_PATTERN_EN
        clear();
        send_ar(BASE + 32'h40, 8'd1, 0);
        wait_done();
        chk("F_beat1", got_d[0], {2{32'd8}});
        chk("F_beat2", got_d[1], {2{32'd9}});
        chk("F_mem_en_pulses", en_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish within 50000 cycles");
        $fatal(1, "timeout");
    end
endmodule
